mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter that answers the CPU's data-memory bus in `System`. The CPU is the initiator: it stores bytes and loads status. The block buffers the bytes in a small FIFO and serializes them 8N1 on `txd`. It decodes its own two-word address window; all other addresses are left to the data memory.

---
 rtl/mmio_uart_tx_pkg.sv | 44 ++++
 rtl/mmio_uart_tx_fifo.sv | 53 +++++
 rtl/mmio_uart_tx.sv | 151 +++++++++++++++
 tb/tb_mmio_uart_tx.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Purpose: shared register offsets, STATUS bit positions and serializer state codes for mmio_uart_tx.
// Latency: n/a (declarations and a pure function only).
// Backpressure: n/a.
package mmio_uart_tx_pkg;

    // Register offsets inside the two-word window; addr[2] selects between them.
    localparam logic [2:0] UART_TXDATA = 3'h0;
    localparam logic [2:0] UART_STATUS = 3'h4;

    // STATUS bit positions.
    localparam int ST_FULL_BIT  = 0;
    localparam int ST_EMPTY_BIT = 1;
    localparam int ST_BUSY_BIT  = 2;
    localparam int ST_OVF_BIT   = 3;
    localparam int ST_CNT_LSB   = 4;

    // Serializer states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_e;

    // Packs the STATUS word; unassigned bits stay zero.
    function automatic logic [31:0] status_word(input logic       full,
                                                input logic       empty,
                                                input logic       busy,
                                                input logic       ovf,
                                                input logic [3:0] cnt);
        logic [31:0] w;
        w               = 32'h0;
        w[ST_FULL_BIT]  = full;
        w[ST_EMPTY_BIT] = empty;
        w[ST_BUSY_BIT]  = busy;
        w[ST_OVF_BIT]   = ovf;
        w[ST_CNT_LSB+:4] = cnt;
        return w;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Purpose: synchronous FIFO (uart_fifo) holding bytes between the bus and the serializer.
// Latency: push visible (non-empty, dout valid) after the push edge; pop takes effect on its edge.
// Backpressure: push while full is accepted only when a pop happens in the same cycle, else ignored.
module uart_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage array; no reset needed since contents are only read when counted valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy separately.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CW'(1);
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Purpose: memory-mapped UART transmitter (TXDATA/STATUS window, FIFO, 8N1 serializer; UART_TX_PARITY_EN adds even parity).
// Latency: store at edge N pops at edge N+1 when idle; txd falls after N+1; frame 10 (11) x CLKS_PER_BIT cycles.
// Backpressure: none on the bus; a store to a full FIFO without a same-cycle pop is dropped and sets sticky overflow.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [31:0] addr,
    input  logic [31:0] writeData,
    input  logic        memWrite,
    input  logic        memRead,
    output logic [31:0] readData,
    output logic        hit,
    output logic        txd
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    tx_state_e     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          ovf_q, ovf_d;
    logic          txd_q, txd_d;

    logic          sel_status, push, ovf_clr, pop, baud_end;
    logic          fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          unused_bits;

    assign hit         = (addr[31:3] == BASE_ADDR[31:3]);
    assign sel_status  = (addr[2] == UART_STATUS[2]);
    assign push        = hit && memWrite && !sel_status;
    assign ovf_clr     = hit && memWrite && sel_status && writeData[ST_OVF_BIT];
    assign baud_end    = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign unused_bits = ^{writeData[31:8], addr[1:0]};

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .resetN (resetN),
        .push   (push),
        .pop    (pop),
        .din    (writeData[7:0]),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // Serial line level for a given state; used on the next-state values so txd is a clean flop.
    function automatic logic line_level(input tx_state_e s, input logic [2:0] idx,
                                        input logic [7:0] sh);
        case (s)
            ST_START:  line_level = 1'b0;
            ST_DATA:   line_level = sh[idx];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: line_level = ^sh;
`endif
            default:   line_level = 1'b1;
        endcase
    endfunction

    // Load data: only STATUS returns a non-zero word, and only during a load to the window.
    always_comb begin
        readData = 32'h0;
        if (hit && memRead && sel_status) begin
            readData = status_word(fifo_full, fifo_empty, state_q != ST_IDLE, ovf_q,
                                   4'(fifo_count));
        end
    end

    // Sticky overflow: a dropped store sets it and wins over a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr)                     ovf_d = 1'b0;
        if (push && fifo_full && !pop)   ovf_d = 1'b1;
    end

    // Serializer next-state: baud counter restarts on every state change.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_end ? '0 : baud_q + BW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    bit_d   = 3'd0;
                    state_d = ST_START;
                end
            end
            ST_START: if (baud_end) state_d = ST_DATA;
            ST_DATA: begin
                if (baud_end) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: if (baud_end) state_d = ST_STOP;
`endif
            ST_STOP:  if (baud_end) state_d = ST_IDLE;
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
            end
        endcase
        txd_d = line_level(state_d, bit_d, shift_d);
    end

    // State registers; reset forces the line high immediately and abandons any frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ovf_q   <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ovf_q   <= ovf_d;
            txd_q   <= txd_d;
        end
    end

    assign txd = txd_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Purpose: directed self-checking bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Latency: checks pop/start timing, bit timing, inter-frame gap and async reset abort.
// Backpressure: exercises the full FIFO, the dropped store and overflow clear.
module tb_mmio_uart_tx;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'hFFFF_0000;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clk = 1'b0;
    logic        resetN;
    logic [31:0] addr, writeData, readData;
    logic        memWrite, memRead, hit, txd;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] bytes_q [6];

    mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .resetN    (resetN),
        .addr      (addr),
        .writeData (writeData),
        .memWrite  (memWrite),
        .memRead   (memRead),
        .readData  (readData),
        .hit       (hit),
        .txd       (txd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        addr      = a;
        writeData = d;
        memWrite  = 1'b1;
        tick();
        memWrite  = 1'b0;
        writeData = 32'h0;
    endtask

    task automatic chk_status(input string tag, input logic [31:0] exp);
        addr    = BASE + 32'h4;
        memRead = 1'b1;
        #1;
        chk(tag, readData, exp);
        memRead = 1'b0;
    endtask

    // Expected line level of frame bit k (0=start, 1..8 data LSB first, then parity/stop).
    function automatic logic fbit(input logic [7:0] b, input int k);
        if (k == 0)                 return 1'b0;
        if (k <= 8)                 return b[k-1];
        if (k == 9 && NBITS == 11)  return ^b;
        return 1'b1;
    endfunction

    // Checks txd cycle by cycle from cycle 'from' of a frame to its end.
    task automatic check_frame(input logic [7:0] b, input int from, input string tag);
        for (int i = from; i < NBITS * CPB; i++) begin
            chk($sformatf("%s_c%0d", tag, i), 32'(txd), 32'(fbit(b, i / CPB)));
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN    = 1'b0;
        addr      = 32'h0;
        writeData = 32'h0;
        memWrite  = 1'b0;
        memRead   = 1'b0;
        bytes_q   = '{8'h11, 8'hA3, 8'h3C, 8'hF0, 8'h81, 8'hEE};

        // Reset state
        #12;
        chk("rst_txd", 32'(txd), 32'h1);
        chk("rst_rdata", readData, 32'h0);
        tick();
        tick();
        resetN = 1'b1;
        tick();
        chk_status("rst_status", 32'h0000_0002);
        chk("hit_status", 32'(hit), 32'h1);

        // Decode and read gating
        addr = BASE + 32'h4;
        #1;
        chk("rd_gated", readData, 32'h0);
        addr    = BASE + 32'h3;
        memRead = 1'b1;
        #1;
        chk("txdata_rd", readData, 32'h0);
        chk("hit_txdata", 32'(hit), 32'h1);
        addr = BASE + 32'h8;
        #1;
        chk("miss_hi_hit", 32'(hit), 32'h0);
        chk("miss_hi_rd", readData, 32'h0);
        addr = 32'hFFFE_0004;
        #1;
        chk("miss_lo_hit", 32'(hit), 32'h0);
        memRead = 1'b0;

        // Single frame 0x55
        store(BASE, 32'h0000_0055);
        chk("pop_latency", 32'(txd), 32'h1);
        tick();
        check_frame(8'h55, 0, "f55");
        chk("f55_idle", 32'(txd), 32'h1);
        chk_status("f55_status", 32'h0000_0002);

        // Five stores fill the FIFO while the first byte is popped, sixth is dropped
        store(BASE, 32'(bytes_q[0]));
        chk("b2b_first_txd", 32'(txd), 32'h1);
        for (int k = 1; k < 5; k++) begin
            store(BASE, 32'(bytes_q[k]));
            chk($sformatf("b2b_txd%0d", k), 32'(txd), 32'(fbit(bytes_q[0], (k - 1) / CPB)));
        end
        chk_status("full_status", 32'h0000_0045);
        store(BASE, 32'(bytes_q[5]));
        chk("drop_txd", 32'(txd), 32'(fbit(bytes_q[0], 4 / CPB)));
        chk_status("ovf_status", 32'h0000_004D);
        store(BASE + 32'h4, 32'h0000_0008);
        chk_status("ovf_clr_status", 32'h0000_0045);
        check_frame(bytes_q[0], 5, "fr0");
        for (int k = 1; k < 5; k++) begin
            chk($sformatf("gap%0d", k), 32'(txd), 32'h1);
            tick();
            check_frame(bytes_q[k], 0, $sformatf("fr%0d", k));
        end
        chk("drain_txd", 32'(txd), 32'h1);
        chk_status("drain_status", 32'h0000_0002);
        tick();
        chk("no_dropped_txd", 32'(txd), 32'h1);

        // Reset mid-frame during data bit 3, with a second byte queued
        store(BASE, 32'h0000_00A5);
        store(BASE, 32'h0000_003C);
        repeat (17) tick();
        chk("pre_rst_txd", 32'(txd), 32'h0);
        #1;
        resetN = 1'b0;
        #1;
        chk("async_rst_txd", 32'(txd), 32'h1);
        chk_status("in_rst_status", 32'h0000_0002);
        tick();
        resetN = 1'b1;
        tick();
        chk_status("post_rst_status", 32'h0000_0002);
        for (int i = 0; i < 3 * NBITS * CPB / 2; i++) begin
            chk($sformatf("post_rst_idle%0d", i), 32'(txd), 32'h1);
            tick();
        end

`ifdef UART_TX_PARITY_EN
        // Parity frame: 0x07 has three ones, so even parity bit is 1
        store(BASE, 32'h0000_0007);
        tick();
        check_frame(8'h07, 0, "par07");
        chk("par_end_txd", 32'(txd), 32'h1);
        chk_status("par_status", 32'h0000_0002);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
